change_dispenser: RTL and testbench
===================================

# change_dispenser

Coin-return unit for the vending machine. It accepts a refund amount in cents (0–15, same 4-bit encoding as the vending machine `balance`) and pays it out as a sequence of one-cycle `dime_out` / `nickel_out` pulses to the coin mechanism, largest coin first. Each coin waits for the mechanism's `coin_ready` and is followed by a settle gap. The block sits between the vending machine's refund path and the coin-ejector driver.

## Interface
- `GAP_CYCLES`, default 1: idle cycles after each coin pulse for mechanism settle; 0 is legal and means no gap.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high; one clock, reset is synchronous and active-high.
- `start` in 1: refund request, sampled only in IDLE.
- `amount` in 4: refund in cents, sampled with `start`.
- `coin_ready` in 1: the mechanism can accept a coin this cycle.
- `dime_out` out 1: one-cycle pulse; eject a dime.
- `nickel_out` out 1: one-cycle pulse; eject a nickel.
- `remaining` out 4: cents still owed in the current transaction.
- `busy` out 1: high whenever state ≠ IDLE.
- `done` out 1: one-cycle pulse; the transaction is complete.
- `error` out 1: one-cycle pulse; the request was rejected.

## Operation
- **Reset values:** state IDLE. `dime_out`, `nickel_out`, `done`, `error`, `busy` = 0. `remaining` = 0. Gap counter = 0.
- **Valid amount:** `amount` ∈ {0, 5, 10, 15}. Any other value is invalid.
- **States:** IDLE, DISPENSE, PULSE, GAP, DONE.
- **IDLE:**
  - `start` with a valid nonzero amount → DISPENSE, `remaining` ← `amount`.
  - `start` with `amount` = 0 → DONE.
  - `start` with an invalid amount → stay in IDLE, `error` = 1 for the next cycle, `remaining` unchanged.
  - No `start` → stay.
- **DISPENSE:** wait for `coin_ready`. When `coin_ready` = 1:
  - Go to PULSE.
  - Select the coin: a dime if `remaining` ≥ 10, else a nickel.
  - On the same edge, decrement `remaining` by 10 or 5.
- **PULSE:** exactly one of `dime_out` / `nickel_out` is high, for exactly this one cycle. Next state is GAP if `GAP_CYCLES` > 0. Otherwise go to DONE if `remaining` = 0, else DISPENSE.
- **GAP:** stay for exactly `GAP_CYCLES` cycles, counted by an internal counter. Then go to DONE if `remaining` = 0, else DISPENSE.
- **DONE:** `done` = 1 for one cycle, then IDLE.
- `start` is ignored in every state except IDLE; there is no queueing.
- `coin_ready` is ignored outside DISPENSE.
- `dime_out` and `nickel_out` are never high together, and never high outside PULSE.
- **Arithmetic:** `remaining` never underflows, because only valid amounts are loaded and the coin choice guarantees an exact decrement. `remaining` is 0 in DONE and holds 0 in IDLE after completion.
- **Reset mid-transaction:** the next edge forces the reset values. A coin pulse in flight is cut off, no `done` is issued, and the unpaid amount is discarded.

## Timing
- Every output is registered or is a pure decode of registered state. There is no combinational path from input to output.
- Take edge 0 as the edge that samples `start`, and `coin_ready` held high. Per coin the sequence is DISPENSE (1 cycle) → PULSE (1) → GAP (`GAP_CYCLES`).
- **Latency:** `done` rises after edge N·(2+`GAP_CYCLES`), where N = 0, 1 or 2 coins. IDLE is re-entered one edge later, and `start` is accepted on that following edge.
- Each cycle that `coin_ready` stays low in DISPENSE adds exactly one cycle.
- `error` rises after edge 0 and falls after edge 1.
- `busy` rises after edge 0 for accepted requests and stays low for rejected ones.

## Structure
- **Shared header `vending_defs.vh`:**
  - `NICKEL_VAL` = 5, `DIME_VAL` = 10, `MAX_AMOUNT` = 15.
  - State encodings for this block.
  - 4-bit amount width shared with the vending machine `balance`.
- **One sub-module, `settle_timer`:** a loadable down-counter of width clog2(`GAP_CYCLES`+1) with a `expired` flag, used by the GAP state. Everything else lives in one FSM module.

## Test plan
- Reset held 2 cycles, then `start` with `amount` = 15, `coin_ready` = 1, `GAP_CYCLES` = 1 → `dime_out` after edge 1, `remaining` = 5; `nickel_out` after edge 4, `remaining` = 0; `done` after edge 6; `busy` low after edge 7.
- `amount` = 10 with `coin_ready` low for 3 cycles in DISPENSE → single `dime_out` delayed by exactly 3 cycles, `nickel_out` never high, `done` after edge 6.
- `amount` = 7, then `amount` = 4'hF+ equivalent invalid 12 → `error` pulse of one cycle each, `busy` stays 0, `remaining` unchanged, no coin pulses.
- `amount` = 0 → `done` after edge 0 with no coin pulses; a new `start` (`amount` = 5) on edge 2 yields one `nickel_out`.
- `start` re-asserted with `amount` = 15 during an active 10-cent transaction → ignored; exactly one dime is paid and `remaining` never exceeds 10.
- `reset` asserted in the PULSE cycle of a 15-cent refund → outputs all 0 after that edge, no `done`; the next `start` (`amount` = 5) operates normally.

Source files
------------

// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the coin-return unit: coin values, amount width, FSM states.
package change_dispenser_pkg;

  localparam int AMT_W = 4;  // matches the vending machine balance width

  localparam logic [AMT_W-1:0] NICKEL_VAL = 4'd5;
  localparam logic [AMT_W-1:0] DIME_VAL   = 4'd10;
  localparam logic [AMT_W-1:0] MAX_AMOUNT = 4'd15;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DISPENSE = 3'd1,
    S_PULSE    = 3'd2,
    S_GAP      = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  // Only whole multiples of a nickel up to 15 cents can be paid out exactly.
  function automatic logic amount_valid(input logic [AMT_W-1:0] a);
    return (a == '0) || (a == NICKEL_VAL) || (a == DIME_VAL) || (a == MAX_AMOUNT);
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Refund request / coin ejector bundle between the vending machine and the dispenser.
interface change_dispenser_if;
  import change_dispenser_pkg::*;

  logic             start;
  logic [AMT_W-1:0] amount;
  logic             coin_ready;
  logic             dime_out;
  logic             nickel_out;
  logic [AMT_W-1:0] remaining;
  logic             busy;
  logic             done;
  logic             error;

  modport master (
    output start, amount, coin_ready,
    input  dime_out, nickel_out, remaining, busy, done, error
  );

  modport slave (
    input  start, amount, coin_ready,
    output dime_out, nickel_out, remaining, busy, done, error
  );
endinterface

// File: rtl/change_dispenser_settle_timer.sv
// Loadable down-counter timing the settle gap after each coin pulse.
module settle_timer #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset)                  cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (dec && cnt != '0)  cnt <= cnt - 1'b1;
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/change_dispenser.sv
// Pays a refund out as dime/nickel pulses, largest coin first, with a settle gap per coin.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int GAP_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  change_dispenser_if.slave    bus
);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  // Loaded in PULSE; GAP leaves on the cycle the counter reads zero, giving GAP_CYCLES cycles.
  localparam logic [GW-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GW'(GAP_CYCLES - 1) : '0;

  state_t           state;
  logic [AMT_W-1:0] remaining;
  logic             dime_q, nickel_q, done_q, error_q;
  logic             gap_expired;

  settle_timer #(.W(GW)) u_settle_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (state == S_PULSE),
    .load_val (GAP_LOAD),
    .dec      (state == S_GAP),
    .expired  (gap_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      remaining <= '0;
      dime_q    <= 1'b0;
      nickel_q  <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      dime_q   <= 1'b0;
      nickel_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            if (!amount_valid(bus.amount)) begin
              error_q <= 1'b1;
            end else if (bus.amount == '0) begin
              state     <= S_DONE;
              remaining <= '0;
              done_q    <= 1'b1;
            end else begin
              state     <= S_DISPENSE;
              remaining <= bus.amount;
            end
          end
        end
        S_DISPENSE: begin
          if (bus.coin_ready) begin
            state <= S_PULSE;
            if (remaining >= DIME_VAL) begin
              dime_q    <= 1'b1;
              remaining <= remaining - DIME_VAL;
            end else begin
              nickel_q  <= 1'b1;
              remaining <= remaining - NICKEL_VAL;
            end
          end
        end
        S_PULSE: begin
          if (GAP_CYCLES > 0) begin
            state <= S_GAP;
          end else if (remaining == '0) begin
            state  <= S_DONE;
            done_q <= 1'b1;
          end else begin
            state <= S_DISPENSE;
          end
        end
        S_GAP: begin
          if (gap_expired) begin
            if (remaining == '0) begin
              state  <= S_DONE;
              done_q <= 1'b1;
            end else begin
              state <= S_DISPENSE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.dime_out   = dime_q;
  assign bus.nickel_out = nickel_q;
  assign bus.done       = done_q;
  assign bus.error      = error_q;
  assign bus.remaining  = remaining;
  assign bus.busy       = (state != S_IDLE);
endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser with GAP_CYCLES = 1.
module tb_change_dispenser;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  change_dispenser_if dif ();

  change_dispenser #(.GAP_CYCLES(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif)
  );

  always #5 clk = ~clk;

  // {busy, done, error, dime_out, nickel_out, remaining[3:0]}
  function automatic logic [8:0] obs();
    return {dif.busy, dif.done, dif.error, dif.dime_out, dif.nickel_out, dif.remaining};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    dif.start = 1'b0;
    dif.amount = 4'd0;
    dif.coin_ready = 1'b1;
    tick();
    tick();
    total++;
    if (obs() !== 9'h000) begin
      bad++;
      $display("FAIL reset_state got=%h want=%h", obs(), 9'h000);
    end
    reset = 1'b0;
  endtask

  task automatic test_fifteen();
    logic [8:0] exp [9] = '{
      {5'b10000, 4'd15}, {5'b10010, 4'd5}, {5'b10000, 4'd5},
      {5'b10000, 4'd5},  {5'b10001, 4'd0}, {5'b10000, 4'd0},
      {5'b11000, 4'd0},  {5'b00000, 4'd0}, {5'b00000, 4'd0}};
    dif.coin_ready = 1'b1;
    dif.start = 1'b1;
    dif.amount = 4'd15;
    for (int k = 0; k < 9; k++) begin
      tick();
      dif.start = 1'b0;
      total++;
      if (obs() !== exp[k]) begin
        bad++;
        $display("FAIL fifteen k=%0d got=%h want=%h", k, obs(), exp[k]);
      end
    end
  endtask

  task automatic test_coin_stall();
    logic [8:0] exp [9] = '{
      {5'b10000, 4'd10}, {5'b10000, 4'd10}, {5'b10000, 4'd10},
      {5'b10000, 4'd10}, {5'b10010, 4'd0},  {5'b10000, 4'd0},
      {5'b11000, 4'd0},  {5'b00000, 4'd0},  {5'b00000, 4'd0}};
    dif.coin_ready = 1'b0;
    dif.start = 1'b1;
    dif.amount = 4'd10;
    for (int k = 0; k < 9; k++) begin
      tick();
      dif.start = 1'b0;
      if (k == 3) dif.coin_ready = 1'b1;
      total++;
      if (obs() !== exp[k]) begin
        bad++;
        $display("FAIL coin_stall k=%0d got=%h want=%h", k, obs(), exp[k]);
      end
    end
  endtask

  task automatic test_invalid();
    logic [3:0] bad_amt [2] = '{4'd7, 4'd12};
    for (int i = 0; i < 2; i++) begin
      dif.start = 1'b1;
      dif.amount = bad_amt[i];
      tick();
      dif.start = 1'b0;
      total++;
      if (obs() !== 9'b0_0100_0000) begin
        bad++;
        $display("FAIL invalid_err amt=%0d got=%h want=%h", bad_amt[i], obs(), 9'b0_0100_0000);
      end
      tick();
      total++;
      if (obs() !== 9'h000) begin
        bad++;
        $display("FAIL invalid_clear amt=%0d got=%h want=%h", bad_amt[i], obs(), 9'h000);
      end
    end
  endtask

  task automatic test_zero_then_nickel();
    logic [8:0] exp [7] = '{
      {5'b11000, 4'd0}, {5'b00000, 4'd0}, {5'b10000, 4'd5},
      {5'b10001, 4'd0}, {5'b10000, 4'd0}, {5'b11000, 4'd0},
      {5'b00000, 4'd0}};
    dif.coin_ready = 1'b1;
    dif.start = 1'b1;
    dif.amount = 4'd0;
    for (int k = 0; k < 7; k++) begin
      tick();
      dif.start = 1'b0;
      if (k == 1) begin
        dif.start = 1'b1;
        dif.amount = 4'd5;
      end
      total++;
      if (obs() !== exp[k]) begin
        bad++;
        $display("FAIL zero_then_nickel k=%0d got=%h want=%h", k, obs(), exp[k]);
      end
    end
  endtask

  task automatic test_start_ignored();
    logic [8:0] exp [6] = '{
      {5'b10000, 4'd10}, {5'b10010, 4'd0}, {5'b10000, 4'd0},
      {5'b11000, 4'd0},  {5'b00000, 4'd0}, {5'b00000, 4'd0}};
    dif.coin_ready = 1'b1;
    dif.start = 1'b1;
    dif.amount = 4'd10;
    for (int k = 0; k < 6; k++) begin
      tick();
      dif.amount = 4'd15;
      if (k == 3) dif.start = 1'b0;
      total++;
      if (obs() !== exp[k]) begin
        bad++;
        $display("FAIL start_ignored k=%0d got=%h want=%h", k, obs(), exp[k]);
      end
    end
  endtask

  task automatic test_reset_mid_pulse();
    logic [8:0] exp  [5] = '{
      {5'b10000, 4'd15}, {5'b10010, 4'd5}, {5'b00000, 4'd0},
      {5'b00000, 4'd0},  {5'b00000, 4'd0}};
    logic [8:0] exp2 [5] = '{
      {5'b10000, 4'd5}, {5'b10001, 4'd0}, {5'b10000, 4'd0},
      {5'b11000, 4'd0}, {5'b00000, 4'd0}};
    dif.coin_ready = 1'b1;
    dif.start = 1'b1;
    dif.amount = 4'd15;
    for (int k = 0; k < 5; k++) begin
      tick();
      dif.start = 1'b0;
      reset = (k == 1);
      total++;
      if (obs() !== exp[k]) begin
        bad++;
        $display("FAIL reset_mid_pulse k=%0d got=%h want=%h", k, obs(), exp[k]);
      end
    end
    dif.start = 1'b1;
    dif.amount = 4'd5;
    for (int k = 0; k < 5; k++) begin
      tick();
      dif.start = 1'b0;
      total++;
      if (obs() !== exp2[k]) begin
        bad++;
        $display("FAIL after_reset_nickel k=%0d got=%h want=%h", k, obs(), exp2[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fifteen();
    test_coin_stall();
    test_invalid();
    test_zero_then_nickel();
    test_start_ignored();
    test_reset_mid_pulse();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
